// File: rtl/hydration_scheduler_if.sv
// Signal bundle between the timer datapath / user buttons and the hydration reminder scheduler.
// master drives time, tick and button pulses; slave (the scheduler) drives the reminder outputs.
interface hydration_scheduler_if;
  logic       tick;
  logic       enable;
  logic [3:0] hMSD;
  logic [3:0] hLSD;
  logic [3:0] mMSD;
  logic [3:0] mLSD;
  logic [3:0] sMSD;
  logic [3:0] sLSD;
  logic       drink;
  logic       snooze;
  logic       remind;
  logic       blink;
  logic [3:0] drinkCount;
  logic       goalMet;
  logic [1:0] state;

  modport master (
    output tick, enable, hMSD, hLSD, mMSD, mLSD, sMSD, sLSD, drink, snooze,
    input  remind, blink, drinkCount, goalMet, state
  );

  modport slave (
    input  tick, enable, hMSD, hLSD, mMSD, mLSD, sMSD, sLSD, drink, snooze,
    output remind, blink, drinkCount, goalMet, state
  );
endinterface

// File: rtl/hydration_scheduler.sv
// Water-reminder scheduler: counts drink intervals on the 1 Hz tick, raises remind/blink, tracks daily drinks.
// Snooze support (SNOOZED state) is compiled in only when HYDRATION_SNOOZE_EN is defined.
module hydration_scheduler #(
  parameter int INTERVAL_S  = 3600,
  parameter int SNOOZE_S    = 300,
  parameter int GOAL        = 8,
  parameter int QUIET_START = 22,
  parameter int QUIET_END   = 7
) (
  input logic                  clk,
  input logic                  reset,
  hydration_scheduler_if.slave bus
);

`ifdef HYDRATION_SNOOZE_EN
  localparam int CNT_MAX = (INTERVAL_S > SNOOZE_S) ? INTERVAL_S : SNOOZE_S;
`else
  localparam int CNT_MAX = INTERVAL_S;
  localparam int unused_snooze_len = SNOOZE_S;
`endif
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_INTERVAL = CNT_W'(INTERVAL_S);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
`ifdef HYDRATION_SNOOZE_EN
  localparam logic [CNT_W-1:0] CNT_SNOOZE   = CNT_W'(SNOOZE_S);
`endif
  localparam logic [4:0] Q_START = 5'(QUIET_START);
  localparam logic [4:0] Q_END   = 5'(QUIET_END);
  localparam logic [3:0] GOAL_V  = 4'(GOAL);

  typedef enum logic [1:0] {
    ST_OFF     = 2'b00,
    ST_WAIT    = 2'b01,
    ST_SNOOZED = 2'b10,
    ST_ALERT   = 2'b11
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       count_q, count_d;
  logic             remind_q, remind_d;
  logic             blink_q, blink_d;
  logic             goal_met_q, goal_met_d;

  logic [4:0] hour;
  logic       quiet;
  logic       midnight;
  logic       drink_taken;
`ifndef HYDRATION_SNOOZE_EN
  logic       unused_snooze_in;
  assign unused_snooze_in = bus.snooze;
`endif

  always_comb begin
    hour = 5'(bus.hMSD) * 5'd10 + 5'(bus.hLSD);
    if (QUIET_START > QUIET_END) quiet = (hour >= Q_START) || (hour < Q_END);
    else                         quiet = (hour >= Q_START) && (hour < Q_END);
    midnight = bus.tick && (bus.hMSD == 4'd0) && (bus.hLSD == 4'd0) && (bus.mMSD == 4'd0)
               && (bus.mLSD == 4'd0) && (bus.sMSD == 4'd0) && (bus.sLSD == 4'd0);
  end

  // Arbitration order: enable low, then drink, then snooze, then tick; losers are dropped.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    count_d     = count_q;
    blink_d     = blink_q;
    drink_taken = 1'b0;
    if (!bus.enable) begin
      state_d = ST_OFF;
      blink_d = 1'b0;
    end else if (state_q == ST_OFF) begin
      state_d = ST_WAIT;
      cnt_d   = CNT_INTERVAL;
    end else if (bus.drink) begin
      drink_taken = 1'b1;
      state_d     = ST_WAIT;
      cnt_d       = CNT_INTERVAL;
      blink_d     = 1'b0;
`ifdef HYDRATION_SNOOZE_EN
    end else if (bus.snooze && (state_q == ST_ALERT)) begin
      state_d = ST_SNOOZED;
      cnt_d   = CNT_SNOOZE;
      blink_d = 1'b0;
`endif
    end else if (bus.tick) begin
      case (state_q)
        ST_WAIT: begin
          if (cnt_q != CNT_ONE) begin
            cnt_d = cnt_q - CNT_ONE;
          end else if (quiet || goal_met_q) begin
            cnt_d = CNT_INTERVAL;
          end else begin
            state_d = ST_ALERT;
            cnt_d   = '0;
            blink_d = 1'b1;
          end
        end
        ST_SNOOZED: begin
          if (cnt_q != CNT_ONE) begin
            cnt_d = cnt_q - CNT_ONE;
          end else begin
            state_d = ST_ALERT;
            cnt_d   = '0;
            blink_d = 1'b1;
          end
        end
        ST_ALERT: blink_d = ~blink_q;
        default: ;
      endcase
    end

    // The midnight clear is independent of state and still counts a drink taken that same cycle.
    if (midnight)                             count_d = drink_taken ? 4'd1 : 4'd0;
    else if (drink_taken && count_q != 4'd15) count_d = count_q + 4'd1;

    goal_met_d = (count_d >= GOAL_V);
    remind_d   = (state_d == ST_ALERT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_OFF;
      cnt_q      <= CNT_INTERVAL;
      count_q    <= 4'd0;
      remind_q   <= 1'b0;
      blink_q    <= 1'b0;
      goal_met_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      count_q    <= count_d;
      remind_q   <= remind_d;
      blink_q    <= blink_d;
      goal_met_q <= goal_met_d;
    end
  end

  assign bus.remind     = remind_q;
  assign bus.blink      = blink_q;
  assign bus.drinkCount = count_q;
  assign bus.goalMet    = goal_met_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_hydration_scheduler.sv
// Scoreboard bench for hydration_scheduler: a driver pushes model-predicted outputs, a monitor compares them.
// Directed scenarios run first, then randomized traffic; honours HYDRATION_SNOOZE_EN when defined.
module tb_hydration_scheduler;
  localparam int INTERVAL_S = 3;
  localparam int SNOOZE_S   = 2;
  localparam int GOAL       = 2;
  localparam int QS         = 22;
  localparam int QE         = 7;
`ifdef HYDRATION_SNOOZE_EN
  localparam bit SNOOZE_EN = 1'b1;
`else
  localparam bit SNOOZE_EN = 1'b0;
`endif
  localparam int M_OFF = 0, M_WAIT = 1, M_SNZ = 2, M_ALERT = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;

  hydration_scheduler_if bus();

  hydration_scheduler #(
    .INTERVAL_S (INTERVAL_S),
    .SNOOZE_S   (SNOOZE_S),
    .GOAL       (GOAL),
    .QUIET_START(QS),
    .QUIET_END  (QE)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       remind;
    logic       blink;
    logic [3:0] count;
    logic       goal;
    logic [1:0] st;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  int   m_state, m_cnt, m_count;
  bit   m_blink;
  int   cur_h, cur_m, cur_s;

  task automatic check_output(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_time(input int h, input int m, input int s);
    cur_h = h; cur_m = m; cur_s = s;
    bus.hMSD = 4'(h / 10); bus.hLSD = 4'(h % 10);
    bus.mMSD = 4'(m / 10); bus.mLSD = 4'(m % 10);
    bus.sMSD = 4'(s / 10); bus.sLSD = 4'(s % 10);
  endtask

  // Reference behaviour written directly from the scheduler rules in plain integers.
  task automatic model_step(input bit en, input bit tk, input bit dr, input bit sn);
    bit took = 1'b0;
    bit quiet = (QS > QE) ? (cur_h >= QS || cur_h < QE) : (cur_h >= QS && cur_h < QE);
    bit at_midnight = tk && cur_h == 0 && cur_m == 0 && cur_s == 0;
    bit goal_now = (m_count >= GOAL);
    if (!en) begin
      m_state = M_OFF;
      m_blink = 1'b0;
    end else if (m_state == M_OFF) begin
      m_state = M_WAIT;
      m_cnt   = INTERVAL_S;
    end else if (dr) begin
      took    = 1'b1;
      m_state = M_WAIT;
      m_cnt   = INTERVAL_S;
      m_blink = 1'b0;
    end else if (SNOOZE_EN && sn && m_state == M_ALERT) begin
      m_state = M_SNZ;
      m_cnt   = SNOOZE_S;
      m_blink = 1'b0;
    end else if (tk) begin
      if (m_state == M_ALERT) begin
        m_blink = !m_blink;
      end else if (m_cnt > 1) begin
        m_cnt = m_cnt - 1;
      end else if (m_state == M_WAIT && (quiet || goal_now)) begin
        m_cnt = INTERVAL_S;
      end else begin
        m_state = M_ALERT;
        m_cnt   = 0;
        m_blink = 1'b1;
      end
    end
    if (at_midnight) m_count = took ? 1 : 0;
    else if (took)   m_count = (m_count >= 15) ? 15 : m_count + 1;
  endtask

  task automatic apply_stimulus(input bit en, input bit tk, input bit dr, input bit sn);
    exp_t e;
    @(negedge clk);
    bus.enable = en; bus.tick = tk; bus.drink = dr; bus.snooze = sn;
    model_step(en, tk, dr, sn);
    e.remind = (m_state == M_ALERT);
    e.blink  = m_blink;
    e.count  = 4'(m_count);
    e.goal   = (m_count >= GOAL);
    e.st     = 2'(m_state);
    exp_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input string tag);
    bus.enable = 1'b0; bus.tick = 1'b0; bus.drink = 1'b0; bus.snooze = 1'b0;
    reset = 1'b1;
    #1;
    check_output({tag, "_remind"}, int'(bus.remind), 0);
    check_output({tag, "_blink"}, int'(bus.blink), 0);
    check_output({tag, "_count"}, int'(bus.drinkCount), 0);
    check_output({tag, "_goal"}, int'(bus.goalMet), 0);
    check_output({tag, "_state"}, int'(bus.state), 0);
    m_state = M_OFF; m_cnt = INTERVAL_S; m_count = 0; m_blink = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Monitor: every active edge the DUT presents a new output word; compare against the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_output("sb_remind", int'(bus.remind), int'(e.remind));
        check_output("sb_blink", int'(bus.blink), int'(e.blink));
        check_output("sb_count", int'(bus.drinkCount), int'(e.count));
        check_output("sb_goal", int'(bus.goalMet), int'(e.goal));
        check_output("sb_state", int'(bus.state), int'(e.st));
      end
    end
  end

  initial begin
    #500000;
    errors++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    bit en, tk, dr, sn;
    set_time(12, 0, 0);
    do_reset("reset_initial");

    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
    check_output("enable_to_wait", int'(bus.state), 1);
    ticks(3);
    check_output("alert_remind", int'(bus.remind), 1);
    check_output("alert_blink_entry", int'(bus.blink), 1);
    check_output("alert_state", int'(bus.state), 3);
    ticks(1);
    check_output("alert_blink_toggle", int'(bus.blink), 0);

    apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0);
    check_output("drink_remind", int'(bus.remind), 0);
    check_output("drink_count", int'(bus.drinkCount), 1);
    check_output("drink_state", int'(bus.state), 1);
    apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0);
    check_output("goal_met", int'(bus.goalMet), 1);
    ticks(3);
    check_output("goal_no_alert", int'(bus.remind), 0);
    check_output("goal_state_wait", int'(bus.state), 1);

    set_time(0, 0, 0);
    ticks(1);
    check_output("midnight_clear", int'(bus.drinkCount), 0);
    check_output("midnight_goal", int'(bus.goalMet), 0);

    set_time(12, 0, 0);
    ticks(2);
    check_output("realert_state", int'(bus.state), 3);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1);
    check_output("snooze_state", int'(bus.state), SNOOZE_EN ? 2 : 3);
    check_output("snooze_remind", int'(bus.remind), SNOOZE_EN ? 0 : 1);
    ticks(2);
    check_output("snooze_expire", int'(bus.state), 3);
    apply_stimulus(1'b1, 1'b0, 1'b1, 1'b1);
    check_output("drink_snooze_state", int'(bus.state), 1);
    check_output("drink_snooze_count", int'(bus.drinkCount), 1);

    set_time(23, 0, 0);
    ticks(3);
    check_output("quiet_no_alert", int'(bus.state), 1);
    set_time(7, 0, 0);
    ticks(3);
    check_output("quiet_end_alert", int'(bus.state), 3);

    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
    check_output("disable_state", int'(bus.state), 0);
    check_output("disable_remind", int'(bus.remind), 0);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
    check_output("reenable_state", int'(bus.state), 1);

    set_time(12, 0, 0);
    for (int k = 0; k < 4; k++) apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0);
    check_output("count_five", int'(bus.drinkCount), 5);
    set_time(0, 0, 0);
    ticks(1);
    check_output("midnight_from_five", int'(bus.drinkCount), 0);
    apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0);
    apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0);
    check_output("midnight_with_drink", int'(bus.drinkCount), 1);

    set_time(12, 0, 0);
    for (int k = 0; k < 16; k++) apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0);
    check_output("count_saturate", int'(bus.drinkCount), 15);
    set_time(0, 0, 0);
    ticks(1);
    set_time(12, 0, 0);
    ticks(2);
    check_output("pre_reset_alert", int'(bus.state), 3);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1);
    do_reset("reset_mid_run");

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        case ($urandom_range(0, 5))
          0: set_time(12, 0, 0);
          1: set_time(23, 0, 0);
          2: set_time(0, 0, 0);
          3: set_time(7, 0, 0);
          4: set_time(6, 59, 59);
          default: set_time(int'($urandom_range(0, 23)), int'($urandom_range(0, 59)), int'($urandom_range(0, 59)));
        endcase
      end
      en = ($urandom_range(0, 39) != 0);
      tk = ($urandom_range(0, 1) == 1);
      dr = ($urandom_range(0, 11) == 0);
      sn = ($urandom_range(0, 5) == 0);
      apply_stimulus(en, tk, dr, sn);
    end

    check_output("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
